// File: rtl/otter_hazard_pkg.sv
// Shared types for the OTTER hazard/forwarding controller: operand select codes, FSM states, shadow stage record.
// Pure declarations; no latency or backpressure of its own.
package otter_hazard_pkg;

  localparam int HZ_REG_W = 5;
  localparam int HZ_SEL_W = 3;

  typedef enum logic [2:0] {
    SRC_REG     = 3'd0,
    SRC_IMM_U   = 3'd1,
    SRC_PC      = 3'd2,
    SRC_IMM_I   = 3'd3,
    SRC_FWD_MEM = 3'd4,
    SRC_FWD_WB  = 3'd5
  } alu_src_sel_t;

  typedef enum logic [1:0] {
    ST_REG     = 2'd0,
    ST_FWD_MEM = 2'd1,
    ST_FWD_WB  = 2'd2
  } st_fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_HOLD = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic                valid;
    logic [HZ_REG_W-1:0] rd;
    logic                reg_we;
    logic                is_load;
    logic [HZ_REG_W-1:0] rs1;
    logic [HZ_REG_W-1:0] rs2;
    logic                rs1_used;
    logic                rs2_used;
    logic [HZ_SEL_W-1:0] base_a;
    logic [HZ_SEL_W-1:0] base_b;
  } shadow_stage_t;

  // A non-register base select from the decoder always wins over forwarding.
  function automatic alu_src_sel_t op_sel(input logic [HZ_SEL_W-1:0] base, input st_fwd_sel_t fwd);
    alu_src_sel_t s;
    s = alu_src_sel_t'(base);
    if (base == SRC_REG) begin
      case (fwd)
        ST_FWD_MEM: s = SRC_FWD_MEM;
        ST_FWD_WB:  s = SRC_FWD_WB;
        default:    s = SRC_REG;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand forward comparator: picks MEM/WB producer for one EX source, MEM has priority, x0 never matches.
// Purely combinational, zero latency; no backpressure.
module fwd_match
  import otter_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = HZ_REG_W
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  used,
  input  logic                  mem_valid,
  input  logic                  mem_we,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  wb_valid,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output st_fwd_sel_t           fwd
);

  always_comb begin
    fwd = ST_REG;
    if (used && (rs != '0)) begin
      if (mem_valid && mem_we && (mem_rd == rs)) fwd = ST_FWD_MEM;
      else if (wb_valid && wb_we && (wb_rd == rs)) fwd = ST_FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// OTTER hazard/forwarding controller: shadow EX/MEM/WB info drives operand selects, load-use stall, branch flush.
// Selects and controls are same-cycle combinational; mem_busy freezes all shadows and defers any taken-branch flush.
module hazard_fwd_ctrl
  import otter_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = HZ_REG_W,
  parameter int SEL_W      = HZ_SEL_W
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  de_valid,
  input  logic [REG_ADDR_W-1:0] de_rs1,
  input  logic [REG_ADDR_W-1:0] de_rs2,
  input  logic                  de_rs1_used,
  input  logic                  de_rs2_used,
  input  logic [REG_ADDR_W-1:0] de_rd,
  input  logic                  de_reg_we,
  input  logic                  de_is_load,
  input  logic [SEL_W-1:0]      de_alu_a_sel,
  input  logic [SEL_W-1:0]      de_alu_b_sel,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  output logic [SEL_W-1:0]      ex_alu_a_sel,
  output logic [SEL_W-1:0]      ex_alu_b_sel,
  output logic [1:0]            ex_st_fwd_sel,
  output logic                  stall_fd,
  output logic                  bubble_ex,
  output logic                  flush_de,
  output logic                  hold_all
);

  shadow_stage_t ex_q, mem_q, wb_q, de_s;
  hz_state_t     state;
  logic          pend_flush;
  st_fwd_sel_t   fwd_a, fwd_b, fwd_st;
  logic          load_use, run, do_flush;
  logic          unused_wb;

  always_comb begin
    de_s          = '0;
    de_s.valid    = de_valid;
    de_s.rd       = de_rd;
    de_s.reg_we   = de_reg_we;
    de_s.is_load  = de_is_load;
    de_s.rs1      = de_rs1;
    de_s.rs2      = de_rs2;
    de_s.rs1_used = de_rs1_used;
    de_s.rs2_used = de_rs2_used;
    de_s.base_a   = de_alu_a_sel;
    de_s.base_b   = de_alu_b_sel;
  end

  fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs(ex_q.rs1), .used(ex_q.valid && ex_q.rs1_used),
    .mem_valid(mem_q.valid), .mem_we(mem_q.reg_we), .mem_rd(mem_q.rd),
    .wb_valid(wb_q.valid), .wb_we(wb_q.reg_we), .wb_rd(wb_q.rd),
    .fwd(fwd_a)
  );

  fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs(ex_q.rs2), .used(ex_q.valid && ex_q.rs2_used),
    .mem_valid(mem_q.valid), .mem_we(mem_q.reg_we), .mem_rd(mem_q.rd),
    .wb_valid(wb_q.valid), .wb_we(wb_q.reg_we), .wb_rd(wb_q.rd),
    .fwd(fwd_b)
  );

  // Store data follows rs2 even when operand B is an immediate.
  fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_st (
    .rs(ex_q.rs2), .used(ex_q.valid && ex_q.rs2_used),
    .mem_valid(mem_q.valid), .mem_we(mem_q.reg_we), .mem_rd(mem_q.rd),
    .wb_valid(wb_q.valid), .wb_we(wb_q.reg_we), .wb_rd(wb_q.rd),
    .fwd(fwd_st)
  );

  assign ex_alu_a_sel  = op_sel(ex_q.base_a, fwd_a);
  assign ex_alu_b_sel  = op_sel(ex_q.base_b, fwd_b);
  assign ex_st_fwd_sel = fwd_st;

  assign load_use = de_valid && ex_q.valid && ex_q.is_load && (ex_q.rd != '0) &&
                    ((de_rs1_used && (de_rs1 == ex_q.rd)) || (de_rs2_used && (de_rs2 == ex_q.rd)));

  assign run       = !RESET && !mem_busy;
  assign do_flush  = run && (ex_branch_taken || pend_flush);
  assign hold_all  = !RESET && mem_busy;
  assign flush_de  = do_flush;
  assign bubble_ex = do_flush || (run && load_use);
  assign stall_fd  = run && !do_flush && load_use;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= RUN;
      pend_flush <= 1'b0;
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
    end else begin
      case (state)
        RUN:      if (mem_busy) state <= MEM_HOLD;
        MEM_HOLD: if (!mem_busy) state <= RUN;
        default:  state <= RUN;
      endcase
      // A branch resolved while frozen is remembered and replayed on release.
      if (mem_busy) begin
        if (ex_branch_taken) pend_flush <= 1'b1;
      end else begin
        pend_flush <= 1'b0;
      end
      if (!mem_busy) begin
        ex_q  <= bubble_ex ? shadow_stage_t'('0) : de_s;
        mem_q <= ex_q;
        wb_q  <= mem_q;
      end
    end
  end

  assign unused_wb = ^{wb_q.is_load, wb_q.rs1, wb_q.rs2, wb_q.rs1_used,
                       wb_q.rs2_used, wb_q.base_a, wb_q.base_b};

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: forwarding, load-use, x0, branch flush, memory hold and reset recovery.
module tb_hazard_fwd_ctrl;
  import otter_hazard_pkg::*;

  logic       CLK, RESET;
  logic       de_valid, de_rs1_used, de_rs2_used, de_reg_we, de_is_load;
  logic [4:0] de_rs1, de_rs2, de_rd;
  logic [2:0] de_alu_a_sel, de_alu_b_sel;
  logic       ex_branch_taken, mem_busy;
  logic [2:0] ex_alu_a_sel, ex_alu_b_sel;
  logic [1:0] ex_st_fwd_sel;
  logic       stall_fd, bubble_ex, flush_de, hold_all;

  int checks = 0;
  int errors = 0;

  hazard_fwd_ctrl #(.REG_ADDR_W(5), .SEL_W(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used), .de_rd(de_rd),
    .de_reg_we(de_reg_we), .de_is_load(de_is_load),
    .de_alu_a_sel(de_alu_a_sel), .de_alu_b_sel(de_alu_b_sel),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .ex_alu_a_sel(ex_alu_a_sel), .ex_alu_b_sel(ex_alu_b_sel),
    .ex_st_fwd_sel(ex_st_fwd_sel), .stall_fd(stall_fd), .bubble_ex(bubble_ex),
    .flush_de(flush_de), .hold_all(hold_all)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic de_set(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic we, input logic ld,
                        input logic [2:0] a, input logic [2:0] b);
    de_valid = 1'b1; de_rd = rd; de_rs1 = rs1; de_rs2 = rs2;
    de_rs1_used = u1; de_rs2_used = u2; de_reg_we = we; de_is_load = ld;
    de_alu_a_sel = a; de_alu_b_sel = b;
  endtask

  task automatic de_none();
    de_valid = 1'b0; de_rd = '0; de_rs1 = '0; de_rs2 = '0;
    de_rs1_used = 1'b0; de_rs2_used = 1'b0; de_reg_we = 1'b0; de_is_load = 1'b0;
    de_alu_a_sel = '0; de_alu_b_sel = '0;
  endtask

  task automatic drain();
    de_none();
    repeat (3) tick();
  endtask

  initial begin
    RESET = 1'b1; ex_branch_taken = 1'b0; mem_busy = 1'b0;
    de_none();
    repeat (2) tick();
    RESET = 1'b0;
    #1;
    chk("rst_a_sel", int'(ex_alu_a_sel), 0);
    chk("rst_b_sel", int'(ex_alu_b_sel), 0);
    chk("rst_st_sel", int'(ex_st_fwd_sel), 0);
    chk("rst_stall", int'(stall_fd), 0);
    chk("rst_bubble", int'(bubble_ex), 0);
    chk("rst_flush", int'(flush_de), 0);
    chk("rst_hold", int'(hold_all), 0);
    chk("rst_state", int'(dut.state), 0);

    // addi x5,x1,imm ; add x5,x5,x6 ; sub x10,x6,x5
    de_set(5'd5, 5'd1, 5'd0, 1, 0, 1, 0, 3'd0, 3'd3); #1;
    chk("fwd_prod_stall", int'(stall_fd), 0);
    tick();
    de_set(5'd5, 5'd5, 5'd6, 1, 1, 1, 0, 3'd0, 3'd0); #1;
    chk("fwd_prod_a", int'(ex_alu_a_sel), 0);
    chk("fwd_prod_b", int'(ex_alu_b_sel), 3);
    chk("fwd_noload_stall", int'(stall_fd), 0);
    tick();
    de_set(5'd10, 5'd6, 5'd5, 1, 1, 1, 0, 3'd0, 3'd0); #1;
    chk("fwd_mem_a", int'(ex_alu_a_sel), 4);
    chk("fwd_mem_b", int'(ex_alu_b_sel), 0);
    chk("fwd_mem_st", int'(ex_st_fwd_sel), 0);
    tick();
    de_none(); #1;
    chk("mem_beats_wb_a", int'(ex_alu_a_sel), 0);
    chk("mem_beats_wb_b", int'(ex_alu_b_sel), 4);
    chk("mem_beats_wb_st", int'(ex_st_fwd_sel), 1);
    drain();

    // lw x7 ; add x8,x7,x7
    de_set(5'd7, 5'd2, 5'd0, 1, 0, 1, 1, 3'd0, 3'd3); #1;
    tick();
    de_set(5'd8, 5'd7, 5'd7, 1, 1, 1, 0, 3'd0, 3'd0); #1;
    chk("lu_stall", int'(stall_fd), 1);
    chk("lu_bubble", int'(bubble_ex), 1);
    chk("lu_flush", int'(flush_de), 0);
    tick();
    #1;
    chk("lu_stall_once", int'(stall_fd), 0);
    chk("lu_bubble_once", int'(bubble_ex), 0);
    chk("lu_bubble_a", int'(ex_alu_a_sel), 0);
    tick();
    de_none(); #1;
    chk("lu_wb_a", int'(ex_alu_a_sel), 5);
    chk("lu_wb_b", int'(ex_alu_b_sel), 5);
    chk("lu_wb_st", int'(ex_st_fwd_sel), 2);
    drain();

    // addi x0 ; lw x0 ; add x11,x0,x0
    de_set(5'd0, 5'd1, 5'd0, 1, 0, 1, 0, 3'd0, 3'd3); #1;
    tick();
    de_set(5'd0, 5'd2, 5'd0, 1, 0, 1, 1, 3'd0, 3'd3); #1;
    tick();
    de_set(5'd11, 5'd0, 5'd0, 1, 1, 1, 0, 3'd0, 3'd0); #1;
    chk("x0_no_stall", int'(stall_fd), 0);
    chk("x0_no_bubble", int'(bubble_ex), 0);
    tick();
    de_none(); #1;
    chk("x0_a", int'(ex_alu_a_sel), 0);
    chk("x0_b", int'(ex_alu_b_sel), 0);
    chk("x0_st", int'(ex_st_fwd_sel), 0);
    drain();

    // Load-use and taken branch together
    de_set(5'd7, 5'd2, 5'd0, 1, 0, 1, 1, 3'd0, 3'd3); #1;
    tick();
    de_set(5'd8, 5'd7, 5'd7, 1, 1, 1, 0, 3'd0, 3'd0);
    ex_branch_taken = 1'b1; #1;
    chk("br_lu_flush", int'(flush_de), 1);
    chk("br_lu_bubble", int'(bubble_ex), 1);
    chk("br_lu_stall", int'(stall_fd), 0);
    tick();
    ex_branch_taken = 1'b0;
    de_none(); #1;
    chk("br_after_flush", int'(flush_de), 0);
    drain();

    // mem_busy for 3 cycles, branch during the second
    de_set(5'd5, 5'd1, 5'd0, 1, 0, 1, 0, 3'd0, 3'd3); #1;
    tick();
    de_set(5'd6, 5'd5, 5'd0, 1, 0, 1, 0, 3'd0, 3'd3); #1;
    tick();
    de_none();
    mem_busy = 1'b1; #1;
    chk("busy1_hold", int'(hold_all), 1);
    chk("busy1_a", int'(ex_alu_a_sel), 4);
    chk("busy1_b", int'(ex_alu_b_sel), 3);
    chk("busy1_flush", int'(flush_de), 0);
    chk("busy1_bubble", int'(bubble_ex), 0);
    tick();
    ex_branch_taken = 1'b1; #1;
    chk("busy2_hold", int'(hold_all), 1);
    chk("busy2_flush", int'(flush_de), 0);
    chk("busy2_state", int'(dut.state), 1);
    chk("busy2_a", int'(ex_alu_a_sel), 4);
    tick();
    ex_branch_taken = 1'b0; #1;
    chk("busy3_hold", int'(hold_all), 1);
    chk("busy3_a", int'(ex_alu_a_sel), 4);
    tick();
    mem_busy = 1'b0; #1;
    chk("rel_hold", int'(hold_all), 0);
    chk("rel_flush", int'(flush_de), 1);
    chk("rel_bubble", int'(bubble_ex), 1);
    chk("rel_stall", int'(stall_fd), 0);
    chk("rel_a", int'(ex_alu_a_sel), 4);
    tick();
    chk("rel_pend_clear", int'(flush_de), 0);
    chk("rel_ex_bubble_a", int'(ex_alu_a_sel), 0);
    drain();

    // Reset during MEM_HOLD
    de_set(5'd5, 5'd1, 5'd0, 1, 0, 1, 0, 3'd0, 3'd3); #1;
    tick();
    de_set(5'd6, 5'd5, 5'd5, 1, 1, 1, 0, 3'd0, 3'd0); #1;
    tick();
    de_none();
    mem_busy = 1'b1;
    tick();
    chk("rh_hold", int'(hold_all), 1);
    chk("rh_state", int'(dut.state), 1);
    chk("rh_a", int'(ex_alu_a_sel), 4);
    RESET = 1'b1;
    mem_busy = 1'b0;
    tick();
    RESET = 1'b0; #1;
    chk("rr_hold", int'(hold_all), 0);
    chk("rr_state", int'(dut.state), 0);
    chk("rr_a", int'(ex_alu_a_sel), 0);
    chk("rr_b", int'(ex_alu_b_sel), 0);
    chk("rr_st", int'(ex_st_fwd_sel), 0);
    chk("rr_flush", int'(flush_de), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Pipeline hazard and forwarding controller for the 5-stage OTTER pipeline. It keeps a shadow register pipeline of destination/source info for the EX, MEM and WB stages. From that it drives the 3-bit selects of the 6-to-1 ALU operand muxes in EX, the store-data forward select, load-use stalls, and branch flushes. It also freezes all pipeline registers while data memory is busy.

## Interface
Parameters:
- REG_ADDR_W, 5, register-index width
- SEL_W, 3, ALU operand mux select width

Ports:
- CLK  in  1  pipeline clock
- RESET  in  1  synchronous, active-high reset
- de_valid  in  1  DE holds a real instruction
- de_rs1, de_rs2  in  REG_ADDR_W  DE source registers
- de_rs1_used, de_rs2_used  in  1  DE instruction reads rs1/rs2
- de_rd  in  REG_ADDR_W  DE destination
- de_reg_we, de_is_load  in  1  DE writes rd / is a load
- de_alu_a_sel, de_alu_b_sel  in  SEL_W  decoder base selects (0=register, 1..3=imm/PC sources)
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- mem_busy  in  1  data memory not ready; whole pipeline must hold
- ex_alu_a_sel, ex_alu_b_sel  out  SEL_W  final EX operand mux selects
- ex_st_fwd_sel  out  2  store-data select: 0 reg, 1 EX/MEM, 2 MEM/WB
- stall_fd  out  1  hold PC, IF/DE register
- bubble_ex  out  1  load NOP into DE/EX register
- flush_de  out  1  invalidate IF/DE register
- hold_all  out  1  freeze every pipeline register

## Operation
- Shadow stages EX, MEM, WB each hold {valid, rd, reg_we, is_load}; EX also holds {rs1, rs2, rs1_used, rs2_used, base_a, base_b}.
- Advance on each edge unless hold_all: EX<-DE fields (or bubble when bubble_ex), MEM<-EX, WB<-MEM. Bubble = valid 0, base selects 0.
- Operand select codes: 0 regfile, 1..3 decoder pass-through, 4 forward EX/MEM result, 5 forward MEM/WB result.
- Operand A: when EX.base_a==0 and EX.rs1_used and EX.rs1!=0, the result is 4 if MEM.valid&&MEM.reg_we&&MEM.rd==EX.rs1. Otherwise it is 5 on a WB match, otherwise 0. Any nonzero base passes through unchanged. MEM beats WB. Same rule for B/rs2. ex_st_fwd_sel uses rs2 regardless of base_b, encoding 1/2.
- Load-use: DE valid, EX.valid&&EX.is_load&&EX.rd!=0, and a used DE source equals EX.rd -> stall_fd=1, bubble_ex=1 for exactly one cycle. The consumer then takes code 5.
- Branch: ex_branch_taken -> flush_de=1, bubble_ex=1, stall_fd=0. It overrides load-use in the same cycle.
- FSM states RUN, MEM_HOLD:
  - RUN -> MEM_HOLD when mem_busy.
  - MEM_HOLD -> RUN when !mem_busy.
  - While MEM_HOLD or mem_busy: hold_all=1, stall_fd/bubble_ex/flush_de=0, shadows frozen, selects stable.
  - ex_branch_taken seen while holding sets pend_flush. On the first RUN cycle it drives flush_de=1, bubble_ex=1, then clears.
- Priority: RESET > mem_busy > (ex_branch_taken | pend_flush) > load-use.

## Timing
- Reset values: all shadows invalid, state RUN, pend_flush 0, all outputs 0.
- Select outputs are combinational from shadow registers only. They are valid in the same cycle the instruction sits in EX.
- stall_fd/bubble_ex/flush_de/hold_all are combinational from de_* inputs, ex_branch_taken, mem_busy and state. There is no registered latency.
- Load-use costs exactly 1 cycle; taken branch costs 2 (DE and EX slots squashed).
- RESET asserted mid-hold or mid-stall returns to RUN with all shadows invalid on the next edge.
- rd==0 never forwards and never stalls.

## Structure
- Package otter_hazard_pkg holds:
  - enum alu_src_sel_t {SRC_REG=0, SRC_IMM_U=1, SRC_PC=2, SRC_IMM_I=3, SRC_FWD_MEM=4, SRC_FWD_WB=5}
  - enum st_fwd_sel_t
  - enum hz_state_t {RUN, MEM_HOLD}
  - struct shadow_stage_t
- One sub-module, fwd_match: a per-operand comparator (rs, used, MEM/WB fields) -> forward code. Instantiated three times (A, B, store).

## Test plan
- EX writes x5, next instruction adds x5+x6 (base 0/0) -> ex_alu_a_sel=4 on the consumer's EX cycle, ex_alu_b_sel=0.
- lw x7 then add x8,x7,x7:
  - DE-cycle stall_fd=1, bubble_ex=1 for 1 cycle.
  - Consumer's EX has a_sel=b_sel=5.
- Writes to x0 in MEM and WB, consumer reads x0 -> selects 0, no stall.
- Load-use and ex_branch_taken in the same cycle -> flush_de=1, bubble_ex=1, stall_fd=0.
- mem_busy high 3 cycles with ex_branch_taken pulsed in cycle 2:
  - hold_all=1 for 3 cycles, selects unchanged.
  - First RUN cycle flush_de=1.
- RESET pulsed during MEM_HOLD -> next cycle hold_all=0, all selects 0, state RUN.
